// File: rtl/common_enums_pkg.sv
// Enumerations shared by the chess-screen control blocks.
package common_enums;

  // Phases of a single chess move, from player hand-off to validator answer.
  typedef enum logic [1:0] {
    PLAYER_SEL = 2'd0,
    PIECE_SEL  = 2'd1,
    POS_SEL    = 2'd2,
    MOVE_VAL   = 2'd3
  } move_state_t;

endpackage

// File: rtl/move_ctrl_wrap_ctr.sv
// Modulo-MOD up/down counter for one cursor axis; wraps at both ends.
module wrap_ctr #(
  parameter  int unsigned MOD = 8,
  localparam int unsigned W   = (MOD > 2) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] val
);

  // Simultaneous inc and dec cancel out and leave the value unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
    end else if (inc && !dec) begin
      val <= (val == W'(MOD - 1)) ? '0 : val + W'(1);
    end else if (dec && !inc) begin
      val <= (val == '0) ? W'(MOD - 1) : val - W'(1);
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// Chess move entry controller: cursor navigation, source/destination latching,
// validator handshake, player rotation and optional per-turn timeout.
module move_ctrl
  import common_enums::*;
#(
  parameter  int unsigned NUM_PLAYERS  = 2,
  parameter  int unsigned BOARD_DIM    = 8,
  parameter  int unsigned TURN_TIMEOUT = 0,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int unsigned CW = (BOARD_DIM > 2) ? $clog2(BOARD_DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_sel,
  input  logic          btn_cancel,
  input  logic          val_ack,
  input  logic          val_ok,
  output move_state_t   state,
  output logic [PW-1:0] player,
  output logic [CW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic [CW-1:0] src_row,
  output logic [CW-1:0] src_col,
  output logic [CW-1:0] dst_row,
  output logic [CW-1:0] dst_col,
  output logic          val_req,
  output logic          move_commit,
  output logic          move_reject,
  output logic          turn_timeout
);

  move_state_t   state_d;
  logic [PW-1:0] player_d;
  logic [PW-1:0] player_next_c;
  logic [CW-1:0] src_row_d, src_col_d, dst_row_d, dst_col_d;
  logic          val_req_d, commit_d, reject_d, timeout_d;
  logic          row_inc_c, row_dec_c, col_inc_c, col_dec_c;
  logic          timer_hit_c;
  logic          at_src_c;

  assign player_next_c = (player == PW'(NUM_PLAYERS - 1)) ? '0 : player + PW'(1);
  assign at_src_c      = (cur_row == src_row) && (cur_col == src_col);

  wrap_ctr #(.MOD(BOARD_DIM)) u_row (
    .clk (clk),
    .rst (rst),
    .inc (row_inc_c),
    .dec (row_dec_c),
    .val (cur_row)
  );

  wrap_ctr #(.MOD(BOARD_DIM)) u_col (
    .clk (clk),
    .rst (rst),
    .inc (col_inc_c),
    .dec (col_dec_c),
    .val (cur_col)
  );

  if (TURN_TIMEOUT > 0) begin : g_timer
    localparam int unsigned TW = $clog2(TURN_TIMEOUT + 1);
    logic [TW-1:0] timer;

    assign timer_hit_c = ((state == PIECE_SEL) || (state == POS_SEL)) &&
                         (timer == TW'(TURN_TIMEOUT - 1));

    // Counts enabled selection cycles; cleared on hand-off, held while validating.
    always_ff @(posedge clk) begin
      if (rst) begin
        timer <= '0;
      end else if (en) begin
        if ((state == PLAYER_SEL) || timer_hit_c) begin
          timer <= '0;
        end else if ((state == PIECE_SEL) || (state == POS_SEL)) begin
          timer <= timer + TW'(1);
        end
      end
    end
  end else begin : g_no_timer
    assign timer_hit_c = 1'b0;
  end

  // Next-state and next-output logic; a timeout outranks any button that cycle.
  always_comb begin
    state_d   = state;
    player_d  = player;
    src_row_d = src_row;
    src_col_d = src_col;
    dst_row_d = dst_row;
    dst_col_d = dst_col;
    val_req_d = val_req;
    commit_d  = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    row_inc_c = 1'b0;
    row_dec_c = 1'b0;
    col_inc_c = 1'b0;
    col_dec_c = 1'b0;
    if (en) begin
      case (state)
        PLAYER_SEL: state_d = PIECE_SEL;
        PIECE_SEL, POS_SEL: begin
          if (timer_hit_c) begin
            timeout_d = 1'b1;
            player_d  = player_next_c;
            state_d   = PLAYER_SEL;
          end else if (btn_cancel) begin
            if (state == POS_SEL) state_d = PIECE_SEL;
          end else if (btn_sel) begin
            if (state == PIECE_SEL) begin
              src_row_d = cur_row;
              src_col_d = cur_col;
              state_d   = POS_SEL;
            end else if (at_src_c) begin
              state_d = PIECE_SEL;
            end else begin
              dst_row_d = cur_row;
              dst_col_d = cur_col;
              val_req_d = 1'b1;
              state_d   = MOVE_VAL;
            end
          end else begin
            row_dec_c = btn_up;
            row_inc_c = btn_down;
            col_dec_c = btn_left;
            col_inc_c = btn_right;
          end
        end
        MOVE_VAL: begin
          if (val_ack) begin
            val_req_d = 1'b0;
            if (val_ok) begin
              commit_d = 1'b1;
              player_d = player_next_c;
              state_d  = PLAYER_SEL;
            end else begin
              reject_d = 1'b1;
              state_d  = POS_SEL;
            end
          end
        end
        default: state_d = PLAYER_SEL;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PLAYER_SEL;
      player       <= '0;
      src_row      <= '0;
      src_col      <= '0;
      dst_row      <= '0;
      dst_col      <= '0;
      val_req      <= 1'b0;
      move_commit  <= 1'b0;
      move_reject  <= 1'b0;
      turn_timeout <= 1'b0;
    end else begin
      state        <= state_d;
      player       <= player_d;
      src_row      <= src_row_d;
      src_col      <= src_col_d;
      dst_row      <= dst_row_d;
      dst_col      <= dst_col_d;
      val_req      <= val_req_d;
      move_commit  <= commit_d;
      move_reject  <= reject_d;
      turn_timeout <= timeout_d;
    end
  end

endmodule
